// File: rtl/hls_run_sequencer.sv
// Sequences one accelerator run: byte preload over slave channel 0, start/done with cycle count, byte readback stream.
// Optional watchdog on the run phase is enabled by defining HLS_SEQ_WATCHDOG_EN (adds wd_expired).
module hls_run_sequencer #(
  parameter int NCH      = 2,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 7,
  parameter int CYC_W    = 32,
  parameter int WD_LIMIT = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  input  logic [ADDR_W-1:0]     rb_base,
  input  logic [ADDR_W-1:0]     rb_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  run_done,
  output logic [CYC_W-1:0]      run_cycles,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [NCH-1:0]        S_oe_ram,
  output logic [NCH-1:0]        S_we_ram,
  output logic [NCH*ADDR_W-1:0] S_addr_ram,
  output logic [NCH*DATA_W-1:0] S_Wdata_ram,
  output logic [NCH*SIZE_W-1:0] S_data_ram_size,
  input  logic [NCH*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [NCH-1:0]        Sout_DataRdy,
`ifdef HLS_SEQ_WATCHDOG_EN
  output logic                  wd_expired,
`endif
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_REQ     = 3'd1,
    S_START      = 3'd2,
    S_RUN        = 3'd3,
    S_READ_SETUP = 3'd4,
    S_RD_REQ     = 3'd5,
    S_RD_OUT     = 3'd6,
    S_FINISH     = 3'd7
  } state_t;

  localparam logic [SIZE_W-1:0] BYTE_SIZE = SIZE_W'(8);
  localparam logic [CYC_W-1:0]  CNT_MAX   = '1;
  localparam logic [CYC_W-1:0]  WD_LIM    = CYC_W'(WD_LIMIT);

  state_t              state;
  logic                we_q;
  logic                oe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic [SIZE_W-1:0]   size_q;
  logic                last_q;
  logic [CYC_W-1:0]    cnt;
  logic [CYC_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   rd_addr_inc;
  logic [ADDR_W-1:0]   remain;
  logic                unused_bits;

  // Both streams are valid/ready: a transfer happens on a rising clock edge where
  // valid and ready are both high; the source holds its payload stable until then.
  assign ld_ready    = (state == S_IDLE) && !reset;
  assign busy        = (state != S_IDLE) && (state != S_FINISH);
  assign run_cycles  = cnt;
  assign dbg_state   = state;
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CYC_W'(1);
  assign rd_addr_inc = rd_addr + ADDR_W'(1);
  assign unused_bits = ^{Sout_Rdata_ram, Sout_DataRdy, WD_LIM};

  // Only channel 0 is ever used; every other channel bit stays 0.
  always_comb begin
    S_oe_ram                     = '0;
    S_we_ram                     = '0;
    S_addr_ram                   = '0;
    S_Wdata_ram                  = '0;
    S_data_ram_size              = '0;
    S_oe_ram[0]                  = oe_q;
    S_we_ram[0]                  = we_q;
    S_addr_ram[ADDR_W-1:0]       = addr_q;
    S_Wdata_ram[7:0]             = wdata_q;
    S_data_ram_size[SIZE_W-1:0]  = size_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      last_q     <= 1'b0;
      cnt        <= '0;
      rd_addr    <= '0;
      remain     <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      run_done   <= 1'b0;
      start_port <= 1'b0;
`ifdef HLS_SEQ_WATCHDOG_EN
      wd_expired <= 1'b0;
`endif
    end else begin
      start_port <= 1'b0;
      run_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            addr_q  <= ld_addr;
            wdata_q <= ld_data;
            size_q  <= BYTE_SIZE;
            last_q  <= ld_last;
            we_q    <= 1'b1;
            state   <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (Sout_DataRdy[0]) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            if (last_q) begin
              start_port <= 1'b1;
              cnt        <= CYC_W'(1);
`ifdef HLS_SEQ_WATCHDOG_EN
              wd_expired <= 1'b0;
`endif
              state      <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_START: begin
          state <= done_port ? S_READ_SETUP : S_RUN;
        end
        S_RUN: begin
          // The done cycle itself is counted, then the counter freezes.
          if (done_port) begin
            cnt   <= cnt_inc;
            state <= S_READ_SETUP;
          end else begin
`ifdef HLS_SEQ_WATCHDOG_EN
            if (cnt_inc >= WD_LIM) begin
              cnt        <= WD_LIM;
              wd_expired <= 1'b1;
              run_done   <= 1'b1;
              state      <= S_FINISH;
            end else begin
              cnt <= cnt_inc;
            end
`else
            cnt <= cnt_inc;
`endif
          end
        end
        S_READ_SETUP: begin
          if (rb_len == '0) begin
            run_done <= 1'b1;
            state    <= S_FINISH;
          end else begin
            rd_addr <= rb_base;
            remain  <= rb_len;
            addr_q  <= rb_base;
            size_q  <= BYTE_SIZE;
            oe_q    <= 1'b1;
            state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (Sout_DataRdy[0]) begin
            oe_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            rd_valid <= 1'b1;
            rd_data  <= Sout_Rdata_ram[7:0];
            rd_last  <= (remain == ADDR_W'(1));
            state    <= S_RD_OUT;
          end
        end
        S_RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_addr  <= rd_addr_inc;
            remain   <= remain - ADDR_W'(1);
            if (remain == ADDR_W'(1)) begin
              run_done <= 1'b1;
              state    <= S_FINISH;
            end else begin
              addr_q <= rd_addr_inc;
              size_q <= BYTE_SIZE;
              oe_q   <= 1'b1;
              state  <= S_RD_REQ;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
- Sequences one run of an HLS-generated accelerator top through its slave memory port and start/done handshake.
- Run order: preload input bytes into the accelerator's internal memory, pulse start_port, wait for done_port while counting cycles, then read back a byte range as a valid/ready stream.
- Sits between a host-side loader (UART or DMA bridge) and the accelerator, replacing the file-driven simulation sequencing in hardware.
- Uses slave channel 0 only; all other channel bits are driven to 0.

Parameters:
- NCH, 2: number of slave memory channels on the accelerator.
- ADDR_W, 10: per-channel byte address width.
- DATA_W, 64: per-channel data width.
- SIZE_W, 7: per-channel access-size field width, in bits.
- CYC_W, 32: width of the run-cycle counter.
- WD_LIMIT, 200000000: watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load byte valid.
- ld_ready  out  1  load byte accepted.
- ld_addr  in  ADDR_W  load byte address.
- ld_data  in  8  load byte value.
- ld_last  in  1  final load byte; run starts after it.
- rb_base  in  ADDR_W  readback start address; sampled at start of readback.
- rb_len  in  ADDR_W  readback byte count; sampled at start of readback; 0 means no readback.
- rd_valid  out  1  readback byte valid.
- rd_ready  in  1  readback consumer ready.
- rd_data  out  8  readback byte.
- rd_last  out  1  final readback byte.
- busy  out  1  high in every state except IDLE and FINISH.
- run_done  out  1  one-cycle pulse on entry to FINISH.
- run_cycles  out  CYC_W  cycles measured for the last run.
- start_port  out  1  accelerator start pulse.
- done_port  in  1  accelerator done.
- S_oe_ram  out  NCH  slave read enable.
- S_we_ram  out  NCH  slave write enable.
- S_addr_ram  out  NCH*ADDR_W  slave address.
- S_Wdata_ram  out  NCH*DATA_W  slave write data.
- S_data_ram_size  out  NCH*SIZE_W  slave access size in bits.
- Sout_Rdata_ram  in  NCH*DATA_W  slave read data.
- Sout_DataRdy  in  NCH  slave access complete.

Behaviour:
- Reset: all outputs 0, run_cycles 0, state IDLE. A reset asserted in any state aborts the run within one cycle: S_* outputs and start_port go 0 and the state returns to IDLE.
- IDLE: ld_ready=1.
  - ld_valid & ld_ready captures address and data, then goes to WR_REQ.
- WR_REQ: drives channel 0 with S_we_ram[0]=1, addr, Wdata[7:0]=byte (upper bits 0), size=8.
  - These are held unchanged until Sout_DataRdy[0]=1, then deasserted the next cycle.
  - Next state is START if the captured byte had ld_last, else IDLE.
  - DataRdy arriving in the same cycle the request is first asserted is legal (1-cycle access).
- START: start_port=1 for exactly one cycle; run_cycles counter loads 1; goes to RUN.
  - If done_port=1 already in the START cycle, goes directly to READ_SETUP with run_cycles=1.
- RUN: counter increments each cycle done_port=0.
  - On done_port=1, counter includes that cycle and freezes; goes to READ_SETUP.
  - Counter saturates at all-ones and never wraps.
- READ_SETUP: samples rb_base and rb_len.
  - len=0 goes to FINISH; otherwise goes to RD_REQ.
- RD_REQ: drives S_oe_ram[0]=1, addr=current, size=8, held until Sout_DataRdy[0]=1.
  - Captures Sout_Rdata_ram[7:0] at DataRdy and goes to RD_OUT.
- RD_OUT: rd_valid=1, rd_data=captured byte, rd_last=1 on the final byte.
  - rd_data and rd_last are held stable while rd_ready=0.
  - On handshake: increment address and decrement remaining; go to RD_REQ, or FINISH after the last byte.
  - Address wraps modulo 2^ADDR_W.
- FINISH: run_done=1 for one cycle; returns to IDLE. run_cycles stays valid until the next START.
- S_we_ram and S_oe_ram are never high in the same cycle.
- At most one outstanding slave access at a time.
- ld_ready=0 in every state except IDLE.

Optional Feature:
- HLS_SEQ_WATCHDOG_EN defined:
  - Adds output wd_expired (1 bit, reset 0).
  - In RUN, if the counter reaches WD_LIMIT without done_port, sets wd_expired=1, skips readback and goes to FINISH with run_cycles=WD_LIMIT.
  - wd_expired clears on the next START.
- Not defined: no wd_expired port; RUN waits for done_port indefinitely.

Test Plan:
- Load 3 bytes (0x0A@0, 0x0B@1, 0x0C@2, last on 3rd) with 2-cycle DataRdy latency -> exactly 3 write requests, each held 2 cycles, size=8; then a single start_port pulse.
- done_port returned 5 cycles after start_port -> run_cycles=6; run_done pulses once.
- done_port high in the START cycle -> run_cycles=1; no RUN state entered.
- rb_base=0x3FE, rb_len=4, rd_ready toggling 1/0 -> bytes read from 0x3FE, 0x3FF, 0x000, 0x001; rd_data stable under stall; rd_last only on the 4th byte.
- Reset asserted mid-RD_REQ -> next cycle all S_* outputs 0, state IDLE, ld_ready=1.
- With HLS_SEQ_WATCHDOG_EN and WD_LIMIT=100, done_port never asserted -> wd_expired=1, run_cycles=100, no readback requests, run_done pulses.
